// File: rtl/door_seq_ctrl_if.sv
// Door controller request/status bundle; master drives car/button inputs, slave is the controller.
interface door_seq_ctrl_if;
   logic       arrive;
   logic       moving;
   logic       open_btn;
   logic       close_btn;
   logic       obstruct;
   logic [1:0] state;
   logic [3:0] sec;
   logic       door_open;
   logic       busy;
   logic       done;

   modport master (
      output arrive, moving, open_btn, close_btn, obstruct,
      input  state, sec, door_open, busy, done
   );

   modport slave (
      input  arrive, moving, open_btn, close_btn, obstruct,
      output state, sec, door_open, busy, done
   );
endinterface

// File: rtl/door_seq_ctrl.sv
// Elevator door sequencer: CLOSED/OPENING/OPEN/CLOSING driven by a one-second tick prescaler.
// All outputs registered; optional obstruction reopen/hold enabled by macro DOOR_OBSTRUCT_EN.
module door_seq_ctrl #(
   parameter int TICK_DIV  = 2,
   parameter int MOVE_SECS = 2,
   parameter int OPEN_SECS = 5
) (
   input  logic            clk,
   input  logic            reseta,
   door_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPENING = 2'd1,
      OPEN    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]    MOVE_LAST = 4'(MOVE_SECS - 1);
   localparam logic [3:0]    OPEN_LAST = 4'(OPEN_SECS - 1);

   state_t        r_state;
   logic [3:0]    r_sec;
   logic [PW-1:0] r_presc;
   logic          r_door_open;
   logic          r_busy;
   logic          r_done;

   state_t w_nxt_state;
   logic   w_tick;
   logic   w_hold_rst;
   logic   w_obst;
   logic   w_door_open_nxt;
   logic   w_busy_nxt;
   logic   w_done_nxt;

   assign w_tick = (r_presc == PRESC_MAX);

`ifdef DOOR_OBSTRUCT_EN
   assign w_obst = bus.obstruct;
`else
   logic w_obst_unused;
   assign w_obst_unused = bus.obstruct;
   assign w_obst        = 1'b0;
`endif

   // State, timer and registered outputs; timers restart on any state change or hold restart.
   always_ff @(posedge clk or posedge reseta) begin
      if (reseta) begin
         r_state     <= CLOSED;
         r_sec       <= 4'd0;
         r_presc     <= '0;
         r_door_open <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_door_open <= w_door_open_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         if ((w_nxt_state != r_state) || w_hold_rst) begin
            r_presc <= '0;
            r_sec   <= 4'd0;
         end else if (w_tick) begin
            r_presc <= '0;
            if (r_sec != 4'd15) begin
               r_sec <= r_sec + 4'd1;
            end
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_hold_rst  = 1'b0;
      case (r_state)
         CLOSED: begin
            if ((bus.arrive || bus.open_btn) && !bus.moving) begin
               w_nxt_state = OPENING;
            end
         end
         OPENING: begin
            if (w_tick && (r_sec == MOVE_LAST)) begin
               w_nxt_state = OPEN;
            end
         end
         OPEN: begin
            if (bus.open_btn) begin
               w_hold_rst = 1'b1;
            end else if (bus.close_btn && !w_obst) begin
               w_nxt_state = CLOSING;
            end else if (w_tick && (r_sec == OPEN_LAST) && !w_obst) begin
               w_nxt_state = CLOSING;
            end
         end
         CLOSING: begin
            // Reopen wins over a close completing in the same cycle.
            if (bus.open_btn || w_obst) begin
               w_nxt_state = OPENING;
            end else if (w_tick && (r_sec == MOVE_LAST)) begin
               w_nxt_state = CLOSED;
            end
         end
         default: w_nxt_state = CLOSED;
      endcase
   end

   always_comb begin
      w_door_open_nxt = (w_nxt_state == OPEN);
      w_busy_nxt      = (w_nxt_state != CLOSED);
      w_done_nxt      = (r_state == CLOSING) && (w_nxt_state == CLOSED);
   end

   assign bus.state     = r_state;
   assign bus.sec       = r_sec;
   assign bus.door_open = r_door_open;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_door_seq_ctrl.sv
// Bench for door_seq_ctrl at TICK_DIV=2, MOVE_SECS=2, OPEN_SECS=5; table rows plus reset corner cases.
module tb_door_seq_ctrl;

   typedef struct {
      logic       arr;
      logic       mov;
      logic       opb;
      logic       clb;
      logic       obs;
      int         n;
      logic [1:0] st;
   } vec_t;

   typedef struct {
      logic [1:0] st;
      logic [3:0] sec;
      logic       dopen;
      logic       busy;
      logic       done;
   } exp_t;

   logic clk;
   logic reseta;

   door_seq_ctrl_if u_if ();

   door_seq_ctrl #(
      .TICK_DIV  (2),
      .MOVE_SECS (2),
      .OPEN_SECS (5)
   ) u_dut (
      .clk    (clk),
      .reseta (reseta),
      .bus    (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t       tbl[$];
   exp_t       sb[$];
   int         checks;
   int         errors;
   int         age;
   logic [1:0] prev_st;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic a, input logic m, input logic o, input logic c,
                      input logic ob, input int n, input logic [1:0] st);
      vec_t v;
      v.arr = a; v.mov = m; v.opb = o; v.clb = c; v.obs = ob; v.n = n; v.st = st;
      tbl.push_back(v);
   endtask

   // Expected timer is derived from cycles spent in the expected state: one tick per two clocks.
   task automatic run_vec(input vec_t v);
      exp_t e;
      exp_t g;
      int   s;
      for (int i = 0; i < v.n; i++) begin
         u_if.arrive    = v.arr;
         u_if.moving    = v.mov;
         u_if.open_btn  = v.opb;
         u_if.close_btn = v.clb;
         u_if.obstruct  = v.obs;
         if (v.st != prev_st) age = 0;
         else if (v.st == 2'd2 && v.opb) age = 0;
         else age++;
         s       = (age / 2 > 15) ? 15 : age / 2;
         e.st    = v.st;
         e.sec   = 4'(s);
         e.dopen = (v.st == 2'd2);
         e.busy  = (v.st != 2'd0);
         e.done  = (prev_st == 2'd3) && (v.st == 2'd0);
         prev_st = v.st;
         sb.push_back(e);
         @(posedge clk);
         @(negedge clk);
         g = sb.pop_front();
         chk("state",     32'(u_if.state),     32'(g.st));
         chk("sec",       32'(u_if.sec),       32'(g.sec));
         chk("door_open", 32'(u_if.door_open), 32'(g.dopen));
         chk("busy",      32'(u_if.busy),      32'(g.busy));
         chk("done",      32'(u_if.done),      32'(g.done));
      end
      u_if.arrive = 1'b0; u_if.moving = 1'b0; u_if.open_btn = 1'b0;
      u_if.close_btn = 1'b0; u_if.obstruct = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".state"},     32'(u_if.state),     32'd0);
      chk({tag, ".sec"},       32'(u_if.sec),       32'd0);
      chk({tag, ".door_open"}, 32'(u_if.door_open), 32'd0);
      chk({tag, ".busy"},      32'(u_if.busy),      32'd0);
      chk({tag, ".done"},      32'(u_if.done),      32'd0);
   endtask

   initial begin
      checks = 0; errors = 0; age = 0; prev_st = 2'd0;
      reseta = 1'b1;
      u_if.arrive = 1'b0; u_if.moving = 1'b0; u_if.open_btn = 1'b0;
      u_if.close_btn = 1'b0; u_if.obstruct = 1'b0;

      // Basic cycle from an arrive pulse.
      add(1,0,0,0,0, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0,10,2'd2);
      add(0,0,0,0,0, 4,2'd3); add(0,0,0,0,0, 2,2'd0);
      // Motion blocks requests; long CLOSED dwell saturates sec.
      add(1,1,1,0,0,20,2'd0); add(0,0,0,0,0,12,2'd0);
      // Hold restart at sec=4.
      add(0,0,1,0,0, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 1,2'd2);
      add(0,0,0,0,0, 8,2'd2); add(0,0,1,0,0, 1,2'd2); add(0,0,0,0,0, 9,2'd2);
      add(0,0,0,0,0, 4,2'd3); add(0,0,0,0,0, 1,2'd0);
      // Buttons ignored while opening; close_btn at sec=1 of OPEN; arrive ignored in OPEN.
      add(1,0,0,0,0, 1,2'd1); add(0,0,0,1,0, 3,2'd1); add(1,0,0,0,0, 3,2'd2);
      add(0,0,0,1,0, 1,2'd3); add(0,0,0,0,0, 3,2'd3); add(0,0,0,0,0, 1,2'd0);
      // Obstruction at sec=1 of CLOSING.
      add(1,0,0,0,0, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 1,2'd2);
      add(0,0,0,1,0, 1,2'd3); add(0,0,0,0,0, 2,2'd3);
`ifdef DOOR_OBSTRUCT_EN
      add(0,0,0,0,1, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 1,2'd2);
      add(0,0,0,1,1, 1,2'd2); add(0,0,0,1,0, 1,2'd3); add(0,0,0,0,0, 3,2'd3);
      add(0,0,0,0,0, 1,2'd0);
`else
      add(0,0,0,0,1, 1,2'd3); add(0,0,0,0,0, 1,2'd0);
`endif
      // open_btn coincides with the final CLOSING tick: reopen, no done.
      add(1,0,0,0,0, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 1,2'd2);
      add(0,0,0,1,0, 1,2'd3); add(0,0,0,0,0, 3,2'd3); add(0,0,1,0,0, 1,2'd1);
      add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 1,2'd2); add(0,0,0,1,0, 1,2'd3);
      add(0,0,0,0,0, 3,2'd3); add(0,0,0,0,0, 1,2'd0);

      repeat (2) @(negedge clk);
      chk_idle("reset");
      reseta = 1'b0;

      for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k]);

      // Asynchronous reset mid-OPEN at sec=3, then the first edge accepts a request.
      tbl.delete();
      add(1,0,0,0,0, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 7,2'd2);
      for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k]);
      chk("pre_rst.sec", 32'(u_if.sec), 32'd3);
      #2 reseta = 1'b1;
      #1 chk_idle("async_rst");
      @(posedge clk);
      #1 chk_idle("rst_held");
      @(negedge clk);
      reseta  = 1'b0;
      prev_st = 2'd0;
      age     = 0;
      tbl.delete();
      add(1,0,0,0,0, 1,2'd1); add(0,0,0,0,0, 3,2'd1); add(0,0,0,0,0, 1,2'd2);
      add(0,0,0,1,0, 1,2'd3); add(0,0,0,0,0, 3,2'd3); add(0,0,0,0,0, 2,2'd0);
      for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
